// File: rtl/tetris_pkg.sv
// Shared geometry, frame image, FSM encoding and cell helpers for the
// 8x16 playfield controller.
package tetris_pkg;

   localparam int ROWS           = 8;
   localparam int COLS           = 16;
   localparam int CELLS          = ROWS * COLS;
   localparam int PLAY_COL_MAX   = 8;
   localparam int PLAY_ROW_MIN   = 1;
   localparam int PLAY_ROW_MAX   = 6;

   localparam logic [15:0] FRAME_ROW_EDGE = 16'h03FF;
   localparam logic [15:0] FRAME_ROW_MID  = 16'h0200;
   localparam logic [CELLS-1:0] FRAME =
      {FRAME_ROW_EDGE, {6{FRAME_ROW_MID}}, FRAME_ROW_EDGE};

   localparam logic [2:0] ST_SPAWN = 3'd0;
   localparam logic [2:0] ST_FALL  = 3'd1;
   localparam logic [2:0] ST_LOCK  = 3'd2;
   localparam logic [2:0] ST_CLEAR = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   function automatic logic [6:0] cell_idx(input logic [2:0] row, input logic [3:0] col);
      return 7'({row, col});
   endfunction

   // A row is full when every playable column 0..PLAY_COL_MAX is set.
   function automatic logic row_full(input logic [CELLS-1:0] cells, input logic [2:0] row);
      return &cells[7'({row, 4'd0}) +: (PLAY_COL_MAX + 1)];
   endfunction

endpackage

// File: rtl/tetris_field_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability filter and a
// one-clock rising-edge pulse on each accepted press.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 250_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic [CW-1:0] cnt;

   // Synced level must differ from the accepted level for DEBOUNCE_CYC clocks in a row.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         pulse <= 1'b0;
         if (sync2 != stable) begin
            if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
               stable <= sync2;
               cnt    <= '0;
               pulse  <= sync2;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/tetris_field_ctrl.sv
// Playfield state machine: single-cell falling piece, gravity, row clearing
// and the registered 128-bit map consumed by the renderer.
module tetris_field_ctrl
   import tetris_pkg::*;
#(
   parameter int GRAVITY_DIV  = 25_000_000,
   parameter int DEBOUNCE_CYC = 250_000,
   parameter int SPAWN_COL    = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Btnl,
   input  logic             Btnr,
   input  logic             Btnd,
   output logic [CELLS-1:0] Map,
   output logic             Game_over,
   output logic [7:0]       Lines
);

   localparam int GW = $clog2(GRAVITY_DIV + 1);

   logic [2:0]       state;
   logic [2:0]       piece_row;
   logic [3:0]       piece_col;
   logic [CELLS-1:0] settled;
   logic [GW-1:0]    grav_cnt;
   logic [2:0]       scan_row;

   logic             left_p;
   logic             right_p;
   logic             down_p;
   logic             tick;
   logic             move_left;
   logic             move_right;
   logic [3:0]       moved_col;
   logic             land;
   logic [CELLS-1:0] piece_mask;
   logic [CELLS-1:0] shifted;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_left  (.clk(Clk), .rst_n(Reset), .btn(Btnl), .pulse(left_p));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_right (.clk(Clk), .rst_n(Reset), .btn(Btnr), .pulse(right_p));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down  (.clk(Clk), .rst_n(Reset), .btn(Btnd), .pulse(down_p));

   assign tick       = (state == ST_FALL) && (grav_cnt == GW'(GRAVITY_DIV - 1));
   assign piece_mask = CELLS'(1) << cell_idx(piece_row, piece_col);
   assign move_left  = left_p & ~right_p & (piece_col != 4'd0)
                     & ~settled[cell_idx(piece_row, piece_col - 4'd1)];
   assign move_right = right_p & ~left_p & (piece_col < 4'(PLAY_COL_MAX))
                     & ~settled[cell_idx(piece_row, piece_col + 4'd1)];
   // Downward step is judged at the column reached after this cycle's sideways move.
   assign land       = (piece_row == 3'(PLAY_ROW_MAX))
                     | settled[cell_idx(piece_row + 3'd1, moved_col)];

   // Post-move column for the current cycle.
   always_comb begin
      moved_col = piece_col;
      if (move_left) begin
         moved_col = piece_col - 4'd1;
      end else if (move_right) begin
         moved_col = piece_col + 4'd1;
      end else begin
         moved_col = piece_col;
      end
   end

   // Rows above the scan row drop by one; the top playable row is emptied.
   always_comb begin
      shifted = settled;
      for (int k = PLAY_ROW_MIN; k <= PLAY_ROW_MAX; k++) begin
         if (3'(k) <= scan_row) begin
            shifted[k*COLS +: COLS] = (k == PLAY_ROW_MIN) ? 16'h0000 : settled[(k-1)*COLS +: COLS];
         end else begin
            shifted[k*COLS +: COLS] = settled[k*COLS +: COLS];
         end
      end
   end

   // Game FSM, gravity counter, settled field, clear scanner and map register.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state     <= ST_SPAWN;
         piece_row <= 3'(PLAY_ROW_MIN);
         piece_col <= 4'(SPAWN_COL);
         settled   <= '0;
         grav_cnt  <= '0;
         scan_row  <= 3'(PLAY_ROW_MAX);
         Map       <= FRAME;
         Game_over <= 1'b0;
         Lines     <= 8'd0;
      end else begin
         Map <= FRAME | settled | ((state == ST_FALL) ? piece_mask : '0);
         case (state)
            ST_SPAWN: begin
               piece_row <= 3'(PLAY_ROW_MIN);
               piece_col <= 4'(SPAWN_COL);
               grav_cnt  <= '0;
               if (settled[cell_idx(3'(PLAY_ROW_MIN), 4'(SPAWN_COL))]) begin
                  state     <= ST_OVER;
                  Game_over <= 1'b1;
               end else begin
                  state <= ST_FALL;
               end
            end
            ST_FALL: begin
               grav_cnt  <= tick ? '0 : grav_cnt + GW'(1);
               piece_col <= moved_col;
               if (tick | down_p) begin
                  if (land) begin
                     state <= ST_LOCK;
                  end else begin
                     piece_row <= piece_row + 3'd1;
                  end
               end
            end
            ST_LOCK: begin
               settled  <= settled | piece_mask;
               scan_row <= 3'(PLAY_ROW_MAX);
               state    <= ST_CLEAR;
            end
            ST_CLEAR: begin
               // A full row is cleared without moving the pointer so the row dropped into it is rechecked.
               if (scan_row == 3'd0) begin
                  state <= ST_SPAWN;
               end else if (row_full(settled, scan_row)) begin
                  settled <= shifted;
                  Lines   <= Lines + 8'd1;
               end else begin
                  scan_row <= scan_row - 3'd1;
               end
            end
            ST_OVER: begin
               state <= ST_OVER;
            end
            default: begin
               state <= ST_SPAWN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tetris_field_ctrl.sv
// Randomized bench for tetris_field_ctrl against a grid-level game model.
module tb_tetris_field_ctrl;

   localparam int GDIV = 4;
   localparam int DCYC = 2;
   localparam int HLEN = 16384;
   localparam logic [127:0] FRAME_C = {16'h03FF, {6{16'h0200}}, 16'h03FF};
   localparam int M_SPAWN = 0, M_FALL = 1, M_LOCK = 2, M_CLEAR = 3, M_OVER = 4;

   logic         Clk = 1'b0;
   logic         Reset = 1'b0;
   logic         Btnl = 1'b0;
   logic         Btnr = 1'b0;
   logic         Btnd = 1'b0;
   logic [127:0] Map;
   logic         Game_over;
   logic [7:0]   Lines;

   tetris_field_ctrl #(.GRAVITY_DIV(GDIV), .DEBOUNCE_CYC(DCYC), .SPAWN_COL(4)) dut (
      .Clk(Clk), .Reset(Reset), .Btnl(Btnl), .Btnr(Btnr), .Btnd(Btnd),
      .Map(Map), .Game_over(Game_over), .Lines(Lines)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit           grid [8][16];
   int           mode, prow, pcol, scan, gcnt, mlines, ecount;
   bit           mgo;
   logic [127:0] mmap;
   bit           rawh [3][HLEN];
   bit           acc  [3];
   bit           pls  [3];

   function automatic logic [127:0] model_map();
      logic [127:0] m = FRAME_C;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 16; c++)
            if (grid[r][c]) m[r*16 + c] = 1'b1;
      if (mode == M_FALL) m[prow*16 + pcol] = 1'b1;
      return m;
   endfunction

   // Synchronized level seen by the filter at edge e (counted from the reset edge).
   function automatic bit synced(input int b, input int e);
      return (e >= 3) ? rawh[b][e-2] : 1'b0;
   endfunction

   task automatic model_edge(input bit rst, input bit l, input bit r, input bit d);
      logic [127:0] nmap;
      bit gl, gr, gd, tick, full, accept;
      int nc;
      if (!rst) begin
         foreach (grid[i, j]) grid[i][j] = 1'b0;
         mode = M_SPAWN; prow = 1; pcol = 4; gcnt = 0; mlines = 0; mgo = 1'b0;
         mmap = FRAME_C; ecount = 0;
         for (int b = 0; b < 3; b++) begin acc[b] = 1'b0; pls[b] = 1'b0; end
         return;
      end
      ecount++;
      rawh[0][ecount] = l; rawh[1][ecount] = r; rawh[2][ecount] = d;
      nmap = model_map();
      gl = pls[0]; gr = pls[1]; gd = pls[2];
      case (mode)
         M_SPAWN: begin
            prow = 1; pcol = 4; gcnt = 0;
            if (grid[1][4]) begin mode = M_OVER; mgo = 1'b1; end
            else mode = M_FALL;
         end
         M_FALL: begin
            nc = pcol;
            if (gl && !gr) begin
               if (pcol > 0) begin if (!grid[prow][pcol-1]) nc = pcol - 1; end
            end else if (gr && !gl) begin
               if (pcol < 8) begin if (!grid[prow][pcol+1]) nc = pcol + 1; end
            end
            pcol = nc;
            tick = (gcnt == GDIV - 1);
            gcnt = tick ? 0 : gcnt + 1;
            if (tick || gd) begin
               if (prow == 6) mode = M_LOCK;
               else if (grid[prow+1][pcol]) mode = M_LOCK;
               else prow++;
            end
         end
         M_LOCK: begin
            grid[prow][pcol] = 1'b1; scan = 6; mode = M_CLEAR;
         end
         M_CLEAR: begin
            if (scan == 0) mode = M_SPAWN;
            else begin
               full = 1'b1;
               for (int c = 0; c <= 8; c++) if (!grid[scan][c]) full = 1'b0;
               if (full) begin
                  for (int k = scan; k >= 2; k--) grid[k] = grid[k-1];
                  for (int c = 0; c < 16; c++) grid[1][c] = 1'b0;
                  mlines = (mlines + 1) % 256;
               end else scan--;
            end
         end
         default: ;
      endcase
      for (int b = 0; b < 3; b++) begin
         accept = 1'b1;
         for (int k = 0; k < DCYC; k++)
            if (ecount - k < 1 || synced(b, ecount - k) == acc[b]) accept = 1'b0;
         pls[b] = accept && !acc[b];
         if (accept) acc[b] = !acc[b];
      end
      mmap = nmap;
   endtask

   // One clock: drive inputs, advance model, compare on the falling edge.
   task automatic cycle(input bit rst, input bit l, input bit r, input bit d);
      Reset = rst; Btnl = l; Btnr = r; Btnd = d;
      model_edge(rst, l, r, d);
      @(posedge Clk);
      @(negedge Clk);
      check_val("map", Map, mmap);
      check_val("game_over", 128'(Game_over), 128'(mgo));
      check_val("lines", 128'(Lines), 128'(mlines));
   endtask

   task automatic press(input int b);
      for (int i = 0; i < 2; i++) cycle(1'b1, b == 0, b == 1, b == 2);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   int  tg [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 2, 8};
   bit  hl, hr, hd, rs;

   initial begin
      @(negedge Clk);
      // reset and first spawn
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("reset_map", Map, FRAME_C);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("spawn_map", Map, FRAME_C | (128'd1 << 20));
      check_val("spawn_go", 128'(Game_over), 128'd0);
      check_val("spawn_lines", 128'(Lines), 128'd0);

      // held left button, then simultaneous left+right
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);

      // steer pieces to fill row 6 with a cell above col 2, then clear it
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      foreach (tg[t]) begin
         int guard = 0;
         while (mode != M_FALL && guard < 60) begin cycle(1'b1, 1'b0, 1'b0, 1'b0); guard++; end
         if (mode != M_FALL) check_val("steer_wait", 128'd0, 128'd1);
         guard = 0;
         while (mode == M_FALL && guard < 200) begin
            if (pcol > tg[t]) press(0);
            else if (pcol < tg[t]) press(1);
            else cycle(1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
         end
      end
      for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("clear_lines", 128'(Lines), 128'd1);
      check_val("clear_drop_bit98", 128'(Map[98]), 128'd1);
      check_val("clear_src_bit82", 128'(Map[82]), 128'd0);

      // idle until column 4 overflows
      for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("over_flag", 128'(Game_over), 128'd1);
      for (int i = 0; i < 24; i++) cycle(1'b1, i[2], i[3], i[1]);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("over_reset_go", 128'(Game_over), 128'd0);
      check_val("over_reset_map", Map, FRAME_C);

      // random play with occasional resets
      hl = 1'b0; hr = 1'b0; hd = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5) == 0) hl = !hl;
         if ($urandom_range(5) == 0) hr = !hr;
         if ($urandom_range(5) == 0) hd = !hd;
         rs = ($urandom_range(499) != 0);
         cycle(rs, hl, hr, hd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
